smart_house_zoned: RTL and testbench

SMART_HOUSE_ZONED -- requirements
Module: smart_house_zoned

---
 rtl/smart_house_pkg.sv | 27 ++
 rtl/zone_climate_fsm.sv | 105 ++++++++++
 rtl/smart_house_zoned.sv | 142 ++++++++++++++
 tb/tb_smart_house_zoned.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/smart_house_pkg.sv
// Shared types and default parameters for the zoned smart-house controller.
// The per-zone climate FSM and the top level both import this package.
package smart_house_pkg;

    typedef enum logic [1:0] {
        CLIMATE_IDLE = 2'd0,
        CLIMATE_HEAT = 2'd1,
        CLIMATE_COOL = 2'd2,
        CLIMATE_VENT = 2'd3
    } climate_state_e;

    localparam int DEFAULT_ZONES         = 4;
    localparam int DEFAULT_TEMP_W        = 32;
    localparam int DEFAULT_T_LOW         = 15;
    localparam int DEFAULT_T_HIGH        = 25;
    localparam int DEFAULT_HYST          = 2;
    localparam int DEFAULT_MIN_ON        = 8;
    localparam int DEFAULT_LIGHT_TIMEOUT = 64;

    // Bits needed to hold values 0..max_value, never less than one.
    function automatic int count_width(input int max_value);
        int w;
        w = $clog2(max_value + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/zone_climate_fsm.sv
// One zone's climate controller: IDLE/HEAT/COOL/VENT state machine with a
// saturating minimum-on counter that holds heating or cooling for MIN_ON cycles.
module zone_climate_fsm
    import smart_house_pkg::*;
#(
    parameter int TEMP_W = DEFAULT_TEMP_W,
    parameter int T_LOW  = DEFAULT_T_LOW,
    parameter int T_HIGH = DEFAULT_T_HIGH,
    parameter int HYST   = DEFAULT_HYST,
    parameter int MIN_ON = DEFAULT_MIN_ON
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              is_day_i,
    input  logic [TEMP_W-1:0] temp_i,
    output logic              heater_o,
    output logic              cooler_o,
    output logic              window_o
);

    localparam int CNT_W = count_width(MIN_ON);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_ON);

    localparam logic [TEMP_W-1:0] HEAT_ON_TH  = TEMP_W'(T_LOW);
    localparam logic [TEMP_W-1:0] HEAT_OFF_TH = TEMP_W'(T_LOW + HYST);
    localparam logic [TEMP_W-1:0] WARM_TH     = TEMP_W'(T_HIGH);
    localparam logic [TEMP_W-1:0] HOT_TH      = TEMP_W'(T_HIGH + HYST);
    localparam logic [TEMP_W-1:0] COOL_OFF_TH = TEMP_W'(T_HIGH - HYST);

    climate_state_e   state_q;
    climate_state_e   state_d;
    logic [CNT_W-1:0] on_cnt_q;
    logic [CNT_W-1:0] on_cnt_d;
    logic             min_on_done;

    assign min_on_done = (on_cnt_q == CNT_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= CLIMATE_IDLE;
            on_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            on_cnt_q <= on_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        on_cnt_d = on_cnt_q;
        case (state_q)
            CLIMATE_IDLE: begin
                if (temp_i < HEAT_ON_TH) begin
                    state_d = CLIMATE_HEAT;
                end else if (temp_i > HOT_TH) begin
                    state_d = CLIMATE_COOL;
                end else if (temp_i > WARM_TH) begin
                    // Mildly warm: open the window by day, otherwise run the cooler.
                    state_d = is_day_i ? CLIMATE_VENT : CLIMATE_COOL;
                end
            end
            CLIMATE_HEAT: begin
                if ((temp_i >= HEAT_OFF_TH) && min_on_done) begin
                    state_d = CLIMATE_IDLE;
                end
            end
            CLIMATE_COOL: begin
                if ((temp_i <= COOL_OFF_TH) && min_on_done) begin
                    state_d = CLIMATE_IDLE;
                end
            end
            CLIMATE_VENT: begin
                if (temp_i > HOT_TH) begin
                    state_d = CLIMATE_COOL;
                end else if ((temp_i <= COOL_OFF_TH) || !is_day_i) begin
                    state_d = CLIMATE_IDLE;
                end
            end
            default: begin
                state_d = CLIMATE_IDLE;
            end
        endcase

        // The counter restarts on every state change, so entering HEAT or COOL
        // always begins a fresh hold; it only advances while heating or cooling.
        if (state_d != state_q) begin
            on_cnt_d = '0;
        end else if (((state_q == CLIMATE_HEAT) || (state_q == CLIMATE_COOL)) && !min_on_done) begin
            on_cnt_d = on_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        heater_o = 1'b0;
        cooler_o = 1'b0;
        window_o = 1'b0;
        case (state_q)
            CLIMATE_HEAT: heater_o = 1'b1;
            CLIMATE_COOL: cooler_o = 1'b1;
            CLIMATE_VENT: window_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/smart_house_zoned.sv
// Multi-zone smart-house controller: per-zone music/light/curtain toggles,
// light auto-off timers, daylight-driven curtains and one climate FSM per zone.
module smart_house_zoned
    import smart_house_pkg::*;
#(
    parameter int ZONES         = DEFAULT_ZONES,
    parameter int TEMP_W        = DEFAULT_TEMP_W,
    parameter int T_LOW         = DEFAULT_T_LOW,
    parameter int T_HIGH        = DEFAULT_T_HIGH,
    parameter int HYST          = DEFAULT_HYST,
    parameter int MIN_ON        = DEFAULT_MIN_ON,
    parameter int LIGHT_TIMEOUT = DEFAULT_LIGHT_TIMEOUT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    is_day,
    input  logic [ZONES-1:0]        music_req,
    input  logic [ZONES-1:0]        light_req,
    input  logic [ZONES-1:0]        curtain_req,
    input  logic [ZONES*TEMP_W-1:0] temp_req,
    output logic [ZONES-1:0]        music,
    output logic [ZONES-1:0]        light,
    output logic [ZONES-1:0]        curtain,
    output logic [ZONES-1:0]        window,
    output logic [ZONES-1:0]        cooler,
    output logic [ZONES-1:0]        heater
);

    localparam int TMR_W = count_width(LIGHT_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LIGHT_TIMEOUT - 1);

    logic [ZONES-1:0] music_req_q;
    logic [ZONES-1:0] light_req_q;
    logic [ZONES-1:0] curtain_req_q;
    logic             is_day_q;

    logic [ZONES-1:0] music_q;
    logic [ZONES-1:0] music_d;
    logic [ZONES-1:0] light_q;
    logic [ZONES-1:0] light_d;
    logic [ZONES-1:0] curtain_q;
    logic [ZONES-1:0] curtain_d;

    logic [ZONES-1:0] music_edge;
    logic [ZONES-1:0] light_edge;
    logic [ZONES-1:0] curtain_edge;
    logic             day_rise;
    logic             day_fall;

    assign music_edge   = music_req & ~music_req_q;
    assign light_edge   = light_req & ~light_req_q;
    assign curtain_edge = curtain_req & ~curtain_req_q;
    assign day_rise     = is_day & ~is_day_q;
    assign day_fall     = ~is_day & is_day_q;

    always_comb begin
        music_d = music_q ^ music_edge;
        // Daylight transitions set every curtain and beat individual requests.
        if (day_rise) begin
            curtain_d = '1;
        end else if (day_fall) begin
            curtain_d = '0;
        end else begin
            curtain_d = curtain_q ^ curtain_edge;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            music_req_q   <= '0;
            light_req_q   <= '0;
            curtain_req_q <= '0;
            is_day_q      <= is_day;
            music_q       <= '0;
            light_q       <= '0;
            curtain_q     <= '0;
        end else begin
            music_req_q   <= music_req;
            light_req_q   <= light_req;
            curtain_req_q <= curtain_req;
            is_day_q      <= is_day;
            music_q       <= music_d;
            light_q       <= light_d;
            curtain_q     <= curtain_d;
        end
    end

    generate
        for (genvar gi = 0; gi < ZONES; gi++) begin : g_zone
            logic [TMR_W-1:0] light_tmr_q;
            logic [TMR_W-1:0] light_tmr_d;
            logic             lit_d;

            always_comb begin
                light_tmr_d = light_tmr_q;
                lit_d       = light_q[gi];
                if (light_edge[gi]) begin
                    lit_d       = ~light_q[gi];
                    light_tmr_d = '0;
                end else if (light_q[gi]) begin
                    if (light_tmr_q == TMR_LAST) begin
                        lit_d       = 1'b0;
                        light_tmr_d = '0;
                    end else begin
                        light_tmr_d = light_tmr_q + TMR_W'(1);
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    light_tmr_q <= '0;
                end else begin
                    light_tmr_q <= light_tmr_d;
                end
            end

            assign light_d[gi] = lit_d;

            zone_climate_fsm #(
                .TEMP_W (TEMP_W),
                .T_LOW  (T_LOW),
                .T_HIGH (T_HIGH),
                .HYST   (HYST),
                .MIN_ON (MIN_ON)
            ) u_climate (
                .clock    (clock),
                .reset    (reset),
                .is_day_i (is_day),
                .temp_i   (temp_req[gi*TEMP_W +: TEMP_W]),
                .heater_o (heater[gi]),
                .cooler_o (cooler[gi]),
                .window_o (window[gi])
            );
        end
    endgenerate

    assign music   = music_q;
    assign light   = light_q;
    assign curtain = curtain_q;

endmodule

// File: tb/tb_smart_house_zoned.sv
// Directed testbench for smart_house_zoned: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences for holds, timeouts and reset.
module tb_smart_house_zoned;

    logic         clock = 1'b0;
    logic         reset;
    logic         is_day;
    logic [3:0]   music_req;
    logic [3:0]   light_req;
    logic [3:0]   curtain_req;
    logic [127:0] temp_req;
    logic [3:0]   music;
    logic [3:0]   light;
    logic [3:0]   curtain;
    logic [3:0]   window;
    logic [3:0]   cooler;
    logic [3:0]   heater;
    logic [23:0]  outs;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        day;
        logic [3:0]  mus;
        logic [3:0]  lit;
        logic [3:0]  cur;
        logic [127:0] temps;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl [21];

    always #5 clock = ~clock;

    assign outs = {music, light, curtain, window, cooler, heater};

    smart_house_zoned #(
        .ZONES         (4),
        .TEMP_W        (32),
        .T_LOW         (15),
        .T_HIGH        (25),
        .HYST          (2),
        .MIN_ON        (8),
        .LIGHT_TIMEOUT (64)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .is_day      (is_day),
        .music_req   (music_req),
        .light_req   (light_req),
        .curtain_req (curtain_req),
        .temp_req    (temp_req),
        .music       (music),
        .light       (light),
        .curtain     (curtain),
        .window      (window),
        .cooler      (cooler),
        .heater      (heater)
    );

    function automatic logic [127:0] temps(input int t0, input int t1, input int t2, input int t3);
        return {32'(t3), 32'(t2), 32'(t1), 32'(t0)};
    endfunction

    // Expected outputs are given per field in port order music..heater.
    function automatic vec_t mk(input logic day, input logic [3:0] mus, input logic [3:0] lit,
                                input logic [3:0] cur, input logic [127:0] t,
                                input logic [3:0] em, input logic [3:0] el, input logic [3:0] ec,
                                input logic [3:0] ew, input logic [3:0] eco, input logic [3:0] eh);
        vec_t v;
        v.day   = day;
        v.mus   = mus;
        v.lit   = lit;
        v.cur   = cur;
        v.temps = t;
        v.exp   = {em, el, ec, ew, eco, eh};
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic do_reset(input logic day);
        reset       = 1'b1;
        is_day      = day;
        music_req   = '0;
        light_req   = '0;
        curtain_req = '0;
        temp_req    = temps(20, 20, 20, 20);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic ok_flag;

        do_reset(1'b0);
        check("reset_state", outs, 24'h0);

        tbl[0]  = mk(0, 4'b0001, 4'b0000, 4'b0000, temps(20,20,20,20), 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tbl[1]  = mk(0, 4'b0001, 4'b0000, 4'b0000, temps(20,20,20,20), 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tbl[2]  = mk(0, 4'b0000, 4'b0000, 4'b0000, temps(20,20,20,20), 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tbl[3]  = mk(0, 4'b0011, 4'b0000, 4'b0000, temps(20,20,20,20), 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tbl[4]  = mk(0, 4'b0000, 4'b0000, 4'b0101, temps(20,20,20,20), 4'b0010, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
        tbl[5]  = mk(0, 4'b0000, 4'b0000, 4'b0000, temps(20,20,20,20), 4'b0010, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
        tbl[6]  = mk(0, 4'b0000, 4'b0000, 4'b1100, temps(20,20,20,20), 4'b0010, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
        tbl[7]  = mk(1, 4'b0000, 4'b0000, 4'b0000, temps(20,20,20,20), 4'b0010, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        tbl[8]  = mk(1, 4'b0000, 4'b0000, 4'b0010, temps(20,20,20,20), 4'b0010, 4'b0000, 4'b1101, 4'b0000, 4'b0000, 4'b0000);
        tbl[9]  = mk(0, 4'b0000, 4'b0000, 4'b0000, temps(20,20,20,20), 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tbl[10] = mk(0, 4'b0000, 4'b0000, 4'b0000, temps(20,20,20,14), 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
        tbl[11] = mk(0, 4'b0000, 4'b0100, 4'b0000, temps(20,20,20,14), 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
        tbl[12] = mk(0, 4'b0000, 4'b0000, 4'b0000, temps(20,20,20,14), 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
        tbl[13] = mk(0, 4'b0000, 4'b0100, 4'b0000, temps(20,20,20,14), 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
        tbl[14] = mk(0, 4'b0000, 4'b0000, 4'b0000, temps(20,20,20,20), 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
        tbl[15] = mk(0, 4'b0000, 4'b0000, 4'b0000, temps(20,20,28,20), 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000);
        tbl[16] = mk(0, 4'b0000, 4'b0000, 4'b0000, temps(20,20,26,20), 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000);
        tbl[17] = mk(0, 4'b0000, 4'b0000, 4'b0000, temps(20,26,26,20), 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b1000);
        tbl[18] = mk(1, 4'b0000, 4'b0000, 4'b0000, temps(26,26,26,20), 4'b0010, 4'b0000, 4'b1111, 4'b0001, 4'b0110, 4'b1000);
        tbl[19] = mk(1, 4'b0000, 4'b0000, 4'b0000, temps(26,26,26,20), 4'b0010, 4'b0000, 4'b1111, 4'b0001, 4'b0110, 4'b0000);
        tbl[20] = mk(1, 4'b0000, 4'b0000, 4'b0000, temps(23,26,26,20), 4'b0010, 4'b0000, 4'b1111, 4'b0000, 4'b0110, 4'b0000);

        for (int i = 0; i < 21; i++) begin
            is_day      = tbl[i].day;
            music_req   = tbl[i].mus;
            light_req   = tbl[i].lit;
            curtain_req = tbl[i].cur;
            temp_req    = tbl[i].temps;
            tick();
            check($sformatf("vec%0d", i), outs, tbl[i].exp);
        end

        // Heating hold: exits only once the on-counter has reached MIN_ON (9th HEAT edge).
        do_reset(1'b0);
        temp_req = temps(10, 20, 20, 20);
        tick();
        check("heat_on", outs, 24'h000001);
        tick();
        tick();
        temp_req = temps(20, 20, 20, 20);
        ok_flag = 1'b1;
        repeat (6) begin
            tick();
            if (heater[0] !== 1'b1) ok_flag = 1'b0;
        end
        check("heat_min_on_hold", {23'b0, ok_flag}, 24'h1);
        tick();
        check("heat_release", outs, 24'h0);

        // Vent by day, escalate to cool, cooling held through nightfall.
        do_reset(1'b0);
        is_day   = 1'b1;
        temp_req = temps(20, 26, 20, 20);
        tick();
        check("vent_day", outs, {4'b0, 4'b0, 4'b1111, 4'b0010, 4'b0, 4'b0});
        temp_req = temps(20, 30, 20, 20);
        tick();
        check("vent_to_cool", outs, {4'b0, 4'b0, 4'b1111, 4'b0, 4'b0010, 4'b0});
        is_day   = 1'b0;
        temp_req = temps(20, 26, 20, 20);
        tick();
        check("cool_night_hold", outs, {4'b0, 4'b0, 4'b0, 4'b0, 4'b0010, 4'b0});

        // Light auto-off after exactly 64 cycles.
        do_reset(1'b0);
        light_req = 4'b0100;
        tick();
        light_req = 4'b0000;
        check("light_on", outs, {4'b0, 4'b0100, 16'b0});
        ok_flag = 1'b1;
        repeat (63) begin
            tick();
            if (light[2] !== 1'b1) ok_flag = 1'b0;
        end
        check("light_held_63", {23'b0, ok_flag}, 24'h1);
        tick();
        check("light_timeout", outs, 24'h0);

        // Second pulse at cycle 40 toggles off; a new pulse gets a full fresh period.
        light_req = 4'b0100;
        tick();
        light_req = 4'b0000;
        repeat (39) tick();
        light_req = 4'b0100;
        tick();
        light_req = 4'b0000;
        check("light_pulse40_off", outs, 24'h0);
        tick();
        light_req = 4'b0100;
        tick();
        light_req = 4'b0000;
        ok_flag = 1'b1;
        repeat (63) begin
            tick();
            if (light[2] !== 1'b1) ok_flag = 1'b0;
        end
        check("light_restart_held", {23'b0, ok_flag}, 24'h1);
        tick();
        check("light_restart_timeout", outs, 24'h0);

        // Held music request toggles once only.
        do_reset(1'b0);
        music_req = 4'b1000;
        tick();
        check("music_first", outs, {4'b1000, 20'b0});
        repeat (9) tick();
        check("music_held_10", outs, {4'b1000, 20'b0});
        music_req = 4'b0000;
        tick();
        check("music_release", outs, {4'b1000, 20'b0});

        // Daylight edges override a simultaneous curtain request.
        do_reset(1'b0);
        curtain_req = 4'b0001;
        tick();
        check("curtain_toggle", outs, {8'b0, 4'b0001, 12'b0});
        curtain_req = 4'b0000;
        tick();
        is_day      = 1'b1;
        curtain_req = 4'b0001;
        tick();
        check("day_overrides_curtain", outs, {8'b0, 4'b1111, 12'b0});
        curtain_req = 4'b0000;
        tick();
        is_day      = 1'b0;
        curtain_req = 4'b0010;
        tick();
        check("night_overrides_curtain", outs, 24'h0);

        // Reset in the middle of a heating hold clears everything at once.
        do_reset(1'b0);
        music_req = 4'b0001;
        temp_req  = temps(10, 20, 20, 20);
        tick();
        music_req = 4'b0000;
        tick();
        tick();
        tick();
        check("heat_cnt3", outs, {4'b0001, 16'b0, 4'b0001});
        reset = 1'b1;
        tick();
        check("reset_aborts_heat", outs, 24'h0);
        reset = 1'b0;
        tick();
        check("heat_after_reset", outs, 24'h000001);

        // is_day held high through reset must not look like a rising edge.
        do_reset(1'b1);
        tick();
        check("no_curtain_edge_after_reset", outs, 24'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
